// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W   : instruction / PC width
//   NOP_INSTR : encoding handed to IF/ID when no instruction is available
//   PC_STEP   : sequential fetch increment
//   fetch_state_e : prefetch FSM states
//   align_pc  : clears the byte-offset bits of a fetch address
package mips_pkg;

  localparam int                 INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [INSTR_W-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
    return {pc[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear and an occupancy count.
//   clk, reset (async, active-low)
//   push/wdata : write an entry (ignored when full unless a pop happens too)
//   pop        : drop the head entry (ignored when empty)
//   clear      : empty the FIFO; wins over push and pop
//   rdata      : head entry, read straight from storage
//   count      : number of occupied entries
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata : single-outstanding fetch port
//   fetch_valid/fetch_instr/fetch_pc4      : queue head toward IF/ID
//   fetch_take                             : IF/ID consumes the head (!Stall)
//   redirect/redirect_pc                   : taken branch/jump, flushes the queue
//   q_count                                : occupied queue entries
module if_prefetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   fetch_valid,
  output logic [31:0]            fetch_instr,
  output logic [31:0]            fetch_pc4,
  input  logic                   fetch_take,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  fetch_state_e  state;
  logic [31:0]   pc;          // address of the current / next request
  logic [31:0]   target;      // redirect PC parked while a stale request drains
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          space;
  logic [63:0]   head;

  // Redirect wins: nothing is pushed or popped in a redirect cycle.
  assign push = (state == FETCH_REQ) && imem_ack && !redirect;
  assign pop  = fetch_take && fetch_valid && !redirect;

  always_comb begin
    count_next = count;
    if (redirect) count_next = '0;
    else          count_next = count + CW'(push) - CW'(pop);
  end

  // No request is outstanding after this cycle's decision point, so a new one
  // may issue whenever the post-update occupancy leaves a free slot.
  assign space = (count_next < DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH_IDLE;
      pc     <= RESET_PC;
      target <= RESET_PC;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (redirect) pc <= align_pc(redirect_pc);
          if (space)    state <= FETCH_REQ;
        end
        FETCH_REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              // Handshake finished this cycle: drop the data, restart at target.
              pc    <= align_pc(redirect_pc);
              state <= FETCH_REQ;
            end else begin
              // Keep the address stable until the memory answers.
              target <= align_pc(redirect_pc);
              state  <= FETCH_DISCARD;
            end
          end else if (imem_ack) begin
            pc    <= pc + PC_STEP;
            state <= space ? FETCH_REQ : FETCH_IDLE;
          end
        end
        FETCH_DISCARD: begin
          if (imem_ack) begin
            pc    <= redirect ? align_pc(redirect_pc) : target;
            state <= FETCH_REQ;
          end else if (redirect) begin
            target <= align_pc(redirect_pc);
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({imem_rdata, pc + PC_STEP}),
    .rdata (head),
    .count (count)
  );

  assign imem_req    = (state != FETCH_IDLE);
  assign imem_addr   = pc;
  assign q_count     = count;
  assign fetch_valid = (count != '0);
  // An empty queue shows a bubble rather than stale storage.
  assign fetch_instr = fetch_valid ? head[63:32] : NOP_INSTR;
  assign fetch_pc4   = fetch_valid ? head[31:0]  : 32'h0;

endmodule
